// File: rtl/butterfly_switch_arbiter_if.sv
// Packet channel: a packet bus plus a valid/ready handshake.
//   packet : PW-bit packet {data, a (source), b (destination), lvl (stage)}
//   valid  : the sender offers a packet
//   ready  : the receiver takes the packet this cycle
// Modports:
//   master : drives packet/valid and samples ready (sending side)
//   slave  : samples packet/valid and drives ready (receiving side)
interface butterfly_switch_arbiter_if #(
  parameter int PW = 41
);
  logic [PW-1:0] packet;
  logic          valid;
  logic          ready;

  modport master (output packet, output valid, input ready);
  modport slave  (input packet, input valid, output ready);
endinterface

// File: rtl/butterfly_switch_arbiter.sv
// 2x2 butterfly switching element with registered outputs.
// Each input picks out0 (straight) or out1 (cross) from bit lvl of (a ^ b).
// When both inputs want the same output, a round-robin pointer per output
// picks the winner. Accepted packets leave one cycle later with lvl + 1.
// Ports:
//   clk            : clock, all state updates on the rising edge
//   reset          : synchronous active-high reset
//   in0, in1       : input channels (slave side; ready is combinational)
//   out0, out1     : registered output channels (master side)
//   conflict_count : saturating count of contended arbitrations
module butterfly_switch_arbiter #(
  parameter int PW = 41,
  parameter int CW = 16
) (
  input  logic                  clk,
  input  logic                  reset,
  butterfly_switch_arbiter_if.slave  in0,
  butterfly_switch_arbiter_if.slave  in1,
  butterfly_switch_arbiter_if.master out0,
  butterfly_switch_arbiter_if.master out1,
  output logic [CW-1:0]         conflict_count
);

  // Inputs and output handshakes gathered into vectors so the per-port
  // logic below can be generated.
  logic [1:0][PW-1:0] in_pkt;
  logic [1:0][PW-1:0] in_pkt_inc;
  logic [1:0]         in_vld;
  logic [1:0]         sel;
  logic [1:0]         out_rdy;
  logic [1:0]         out_vld;
  logic [1:0][PW-1:0] out_pkt;
  logic [1:0][1:0]    grant;     // grant[j][i]: input i granted to output j
  logic [1:0]         contend;

  assign in_pkt[0]  = in0.packet;
  assign in_pkt[1]  = in1.packet;
  assign in_vld[0]  = in0.valid;
  assign in_vld[1]  = in1.valid;
  assign out_rdy[0] = out0.ready;
  assign out_rdy[1] = out1.ready;

  // Route computation and level increment per input.
  genvar gi;
  generate
    for (gi = 0; gi < 2; gi++) begin : g_route
      logic [3:0] ab;
      assign ab = in_pkt[gi][10:7] ^ in_pkt[gi][6:3];
      // Levels 4..7 index past the 4-bit address, so they route straight.
      assign sel[gi] = in_pkt[gi][2] ? 1'b0 : ab[in_pkt[gi][1:0]];
      // data, a and b pass through; lvl wraps naturally at 3 bits.
      assign in_pkt_inc[gi] = {in_pkt[gi][PW-1:3], in_pkt[gi][2:0] + 3'd1};
    end
  endgenerate

  // Per-output arbitration and output register.
  generate
    for (gi = 0; gi < 2; gi++) begin : g_out
      logic [1:0]    req;
      logic          free;
      logic [1:0]    grant_l;
      logic          rr_reg;
      logic          rr_next;
      logic          vld_reg;
      logic          vld_next;
      logic [PW-1:0] pkt_reg;
      logic [PW-1:0] pkt_next;

      assign req[0] = in_vld[0] && (sel[0] == 1'(gi));
      assign req[1] = in_vld[1] && (sel[1] == 1'(gi));
      // A full register that drains this cycle can be reloaded at once.
      assign free   = !vld_reg || out_rdy[gi];

      always_comb begin
        grant_l = 2'b00;
        rr_next = rr_reg;
        if (free) begin
          case (req)
            2'b01:   grant_l = 2'b01;
            2'b10:   grant_l = 2'b10;
            2'b11: begin
              // rr_reg names the favoured input; hand priority to the other.
              grant_l = rr_reg ? 2'b10 : 2'b01;
              rr_next = ~rr_reg;
            end
            default: grant_l = 2'b00;
          endcase
        end
      end

      always_comb begin
        vld_next = (|grant_l) || (vld_reg && !out_rdy[gi]);
        pkt_next = pkt_reg;
        if (grant_l[0]) begin
          pkt_next = in_pkt_inc[0];
        end else if (grant_l[1]) begin
          pkt_next = in_pkt_inc[1];
        end
      end

      always_ff @(posedge clk) begin
        if (reset) begin
          rr_reg  <= 1'b0;
          vld_reg <= 1'b0;
          pkt_reg <= '0;
        end else begin
          rr_reg  <= rr_next;
          vld_reg <= vld_next;
          pkt_reg <= pkt_next;
        end
      end

      assign grant[gi]   = grant_l;
      assign contend[gi] = free && (&req);
      assign out_vld[gi] = vld_reg;
      assign out_pkt[gi] = pkt_reg;
    end
  endgenerate

  // Both inputs can only contend for one output at a time, so the counter
  // advances by at most one per cycle.
  logic [CW-1:0] cnt_reg;
  logic [CW-1:0] cnt_next;

  always_comb begin
    cnt_next = cnt_reg;
    if ((|contend) && (cnt_reg != {CW{1'b1}})) begin
      cnt_next = cnt_reg + CW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_reg <= '0;
    end else begin
      cnt_reg <= cnt_next;
    end
  end

  // Grants are ignored while reset is high, so ready is masked too.
  assign in0.ready      = !reset && (grant[0][0] || grant[1][0]);
  assign in1.ready      = !reset && (grant[0][1] || grant[1][1]);
  assign out0.packet    = out_pkt[0];
  assign out0.valid     = out_vld[0];
  assign out1.packet    = out_pkt[1];
  assign out1.valid     = out_vld[1];
  assign conflict_count = cnt_reg;

endmodule

// File: tb/tb_butterfly_switch_arbiter.sv
module tb_butterfly_switch_arbiter;
  localparam int PW = 41;
  localparam int CW = 16;

  logic          clk;
  logic          reset;
  logic [CW-1:0] conflict_count;
  int            checks;
  int            errors;

  butterfly_switch_arbiter_if #(.PW(PW)) in0_if ();
  butterfly_switch_arbiter_if #(.PW(PW)) in1_if ();
  butterfly_switch_arbiter_if #(.PW(PW)) out0_if ();
  butterfly_switch_arbiter_if #(.PW(PW)) out1_if ();

  butterfly_switch_arbiter #(.PW(PW), .CW(CW)) dut (
    .clk            (clk),
    .reset          (reset),
    .in0            (in0_if),
    .in1            (in1_if),
    .out0           (out0_if),
    .out1           (out1_if),
    .conflict_count (conflict_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [PW-1:0] mk(input logic [29:0] d, input logic [3:0] a,
                                       input logic [3:0] b, input logic [2:0] l);
    return {d, a, b, l};
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Inputs change 1 time unit after the rising edge; registered outputs are
  // also sampled there, combinational ready is sampled at the falling edge.
  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  initial begin
    checks = 0;
    errors = 0;

    // ---------------- reset with both inputs requesting
    reset          = 1'b1;
    in0_if.packet  = mk(30'h1, 4'd0, 4'd0, 3'd0);
    in1_if.packet  = mk(30'h2, 4'd1, 4'd0, 3'd0);
    in0_if.valid   = 1'b1;
    in1_if.valid   = 1'b1;
    out0_if.ready  = 1'b1;
    out1_if.ready  = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    $display("txn reset: both inputs valid under reset");
    chk("rst_in0_ready", in0_if.ready, 0);
    chk("rst_in1_ready", in1_if.ready, 0);
    chk("rst_out0_valid", out0_if.valid, 0);
    chk("rst_out1_valid", out1_if.valid, 0);
    chk("rst_out0_packet", out0_if.packet, 0);
    chk("rst_out1_packet", out1_if.packet, 0);
    chk("rst_count", conflict_count, 0);
    next_cycle();
    reset        = 1'b0;
    in0_if.valid = 1'b0;
    in1_if.valid = 1'b0;

    // ---------------- single route: a^b = 6, lvl 1 -> cross
    in0_if.packet = mk(30'h1234, 4'd3, 4'd5, 3'd1);
    in0_if.valid  = 1'b1;
    @(negedge clk);
    $display("txn single: in0 data=0x1234 a=3 b=5 lvl=1");
    chk("single_in0_ready", in0_if.ready, 1);
    chk("single_in1_ready", in1_if.ready, 0);
    next_cycle();
    in0_if.valid = 1'b0;
    chk("single_out1_valid", out1_if.valid, 1);
    chk("single_out1_packet", out1_if.packet, mk(30'h1234, 4'd3, 4'd5, 3'd2));
    chk("single_out0_valid", out0_if.valid, 0);

    // ---------------- contention on out0: in0, in1, in0, in1
    in0_if.packet = mk(30'h100, 4'd2, 4'd0, 3'd0);
    in1_if.packet = mk(30'h200, 4'd2, 4'd0, 3'd0);
    in0_if.valid  = 1'b1;
    in1_if.valid  = 1'b1;
    for (int k = 0; k < 4; k++) begin
      logic [PW-1:0] exp_pkt;
      @(negedge clk);
      $display("txn contend %0d: expect grant to in%0d", k, k % 2);
      chk("contend_in0_ready", in0_if.ready, (k % 2 == 0) ? 1 : 0);
      chk("contend_in1_ready", in1_if.ready, (k % 2 == 1) ? 1 : 0);
      exp_pkt = (k % 2 == 0) ? mk(30'h100 + 30'(k), 4'd2, 4'd0, 3'd1)
                             : mk(30'h200 + 30'(k), 4'd2, 4'd0, 3'd1);
      next_cycle();
      chk("contend_out0_packet", out0_if.packet, exp_pkt);
      chk("contend_out0_valid", out0_if.valid, 1);
      // The granted source presents its next packet; the other holds.
      if (k % 2 == 0) in0_if.packet = mk(30'h100 + 30'(k + 2), 4'd2, 4'd0, 3'd0);
      else            in1_if.packet = mk(30'h200 + 30'(k + 2), 4'd2, 4'd0, 3'd0);
      // Keep in1's waiting packet tagged with the cycle it will be served.
      if (k % 2 == 0) in1_if.packet = mk(30'h200 + 30'(k + 1), 4'd2, 4'd0, 3'd0);
      else            in0_if.packet = mk(30'h100 + 30'(k + 1), 4'd2, 4'd0, 3'd0);
    end
    chk("contend_count", conflict_count, 4);
    in0_if.valid = 1'b0;
    in1_if.valid = 1'b0;

    // ---------------- parallel: in0 -> out0, in1 -> out1
    in0_if.packet = mk(30'h55, 4'd0, 4'd0, 3'd0);
    in1_if.packet = mk(30'h66, 4'd1, 4'd0, 3'd0);
    in0_if.valid  = 1'b1;
    in1_if.valid  = 1'b1;
    @(negedge clk);
    $display("txn parallel: in0->out0, in1->out1");
    chk("par_in0_ready", in0_if.ready, 1);
    chk("par_in1_ready", in1_if.ready, 1);
    next_cycle();
    in0_if.valid = 1'b0;
    in1_if.valid = 1'b0;
    chk("par_out0_valid", out0_if.valid, 1);
    chk("par_out0_packet", out0_if.packet, mk(30'h55, 4'd0, 4'd0, 3'd1));
    chk("par_out1_valid", out1_if.valid, 1);
    chk("par_out1_packet", out1_if.packet, mk(30'h66, 4'd1, 4'd0, 3'd1));
    chk("par_count", conflict_count, 4);

    // ---------------- backpressure on out0 for 3 cycles
    out0_if.ready = 1'b0;
    in0_if.packet = mk(30'h77, 4'd0, 4'd0, 3'd0);
    in0_if.valid  = 1'b1;
    in1_if.packet = mk(30'h88, 4'd1, 4'd0, 3'd0);
    in1_if.valid  = 1'b1;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      $display("txn stall %0d: out0 full, out0_ready=0", k);
      chk("bp_in0_ready", in0_if.ready, 0);
      if (k == 0) chk("bp_in1_ready_other_output", in1_if.ready, 1);
      next_cycle();
      in1_if.valid = 1'b0;
      chk("bp_out0_valid", out0_if.valid, 1);
      chk("bp_out0_packet", out0_if.packet, mk(30'h55, 4'd0, 4'd0, 3'd1));
    end
    chk("bp_out1_packet", out1_if.packet, mk(30'h88, 4'd1, 4'd0, 3'd1));
    out0_if.ready = 1'b1;
    @(negedge clk);
    $display("txn release: out0_ready=1, in0 reloads out0");
    chk("bp_release_in0_ready", in0_if.ready, 1);
    next_cycle();
    in0_if.valid = 1'b0;
    chk("bp_release_out0_valid", out0_if.valid, 1);
    chk("bp_release_out0_packet", out0_if.packet, mk(30'h77, 4'd0, 4'd0, 3'd1));
    chk("bp_count", conflict_count, 4);

    // ---------------- level wrap: lvl 7 routes straight, wraps to 0
    in1_if.packet = mk(30'h99, 4'd5, 4'd9, 3'd7);
    in1_if.valid  = 1'b1;
    @(negedge clk);
    $display("txn wrap: in1 lvl=7");
    chk("wrap_in1_ready", in1_if.ready, 1);
    next_cycle();
    in1_if.valid = 1'b0;
    chk("wrap_out0_valid", out0_if.valid, 1);
    chk("wrap_out0_packet", out0_if.packet, mk(30'h99, 4'd5, 4'd9, 3'd0));
    chk("wrap_out1_valid", out1_if.valid, 0);

    // ---------------- reset mid-flight with out1 held full
    out1_if.ready = 1'b0;
    in0_if.packet = mk(30'hAB, 4'd1, 4'd0, 3'd0);
    in0_if.valid  = 1'b1;
    next_cycle();
    in0_if.valid = 1'b0;
    chk("mid_out1_valid", out1_if.valid, 1);
    reset         = 1'b1;
    in1_if.packet = mk(30'hCD, 4'd0, 4'd0, 3'd0);
    in1_if.valid  = 1'b1;
    @(negedge clk);
    $display("txn midreset: reset with out1 full and in1 requesting out0");
    chk("mid_in1_ready", in1_if.ready, 0);
    next_cycle();
    reset = 1'b0;
    in1_if.valid = 1'b0;
    out1_if.ready = 1'b1;
    chk("mid_out1_valid_cleared", out1_if.valid, 0);
    chk("mid_out1_packet_cleared", out1_if.packet, 0);
    chk("mid_out0_valid_cleared", out0_if.valid, 0);
    chk("mid_count_cleared", conflict_count, 0);

    // rr0 back to favouring input 0
    in0_if.packet = mk(30'h11, 4'd0, 4'd0, 3'd0);
    in1_if.packet = mk(30'h22, 4'd0, 4'd0, 3'd0);
    in0_if.valid  = 1'b1;
    in1_if.valid  = 1'b1;
    @(negedge clk);
    $display("txn post-reset contention on out0");
    chk("post_in0_ready", in0_if.ready, 1);
    chk("post_in1_ready", in1_if.ready, 0);
    next_cycle();
    in0_if.valid = 1'b0;
    in1_if.valid = 1'b0;
    chk("post_out0_packet", out0_if.packet, mk(30'h11, 4'd0, 4'd0, 3'd1));
    chk("post_count", conflict_count, 1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/butterfly_switch_arbiter.md
# butterfly_switch_arbiter

Registered 2x2 butterfly switching element that shares two output channels between two packet inputs. For each input it computes the route bit from the packet's source/destination/level fields, arbitrates round-robin when both inputs target the same output, and increments the level field. It sits at every stage of the butterfly network, and its outputs feed the next stage's inputs.

## Interface
- PW, 41: packet width; fixed layout {data[40:11], a[10:7] source, b[6:3] destination, lvl[2:0] stage}
- CW, 16: width of the conflict counter
- clk  input  1  clock; all state updates on rising edge
- reset  input  1  synchronous, active-high reset
- in0_packet  input  PW  packet on input 0
- in0_valid  input  1  input 0 offers a packet
- in0_ready  output  1  input 0 packet accepted this cycle
- in1_packet / in1_valid / in1_ready: same as input 0, for input 1
- out0_packet  output  PW  registered packet on output 0 (straight channel)
- out0_valid  output  1  out0_packet holds a packet
- out0_ready  input  1  downstream takes out0_packet this cycle
- out1_packet / out1_valid / out1_ready: same as output 0, for output 1 (cross channel)
- conflict_count  output  CW  saturating count of contended arbitrations

## Operation
- Route select, per input i: sel_i = bit lvl of (a ^ b), i.e. ((a^b) >> lvl) & 1.
  - lvl 4..7 always gives sel = 0.
  - sel 0 targets out0; sel 1 targets out1.
- Output j is free when !outj_valid, or when outj_valid && outj_ready (drain and reload in the same cycle).
- Arbitration runs independently for each output j:
  - Requesters are the inputs with in_valid whose sel equals j.
  - No requester, or output not free: no grant.
  - One requester: grant it; rr_j is unchanged.
  - Two requesters: grant the input named by rr_j, then set rr_j to the other input. conflict_count increments, saturating at 2^CW-1.
- Two inputs targeting different outputs are both granted in the same cycle when both outputs are free.
- in_ready_i is high iff input i is granted.
  - It is combinational from in_valid, in_packet, outj_valid and outj_ready.
  - in_ready_i is never high while in_valid_i is low.
- Source rule: in_packet and in_valid must stay stable from assertion until in_ready is seen.
- On a grant, the output register loads {data, a, b, lvl+1}.
  - lvl is 3-bit and wraps 7 -> 0.
  - data, a and b pass through unmodified.
- Output register bookkeeping, per output:
  - Register loaded: outj_valid = 1.
  - Drained without a reload: outj_valid = 0; outj_packet keeps its stale value.
  - Not drained and not loaded: register holds.
- State elements: two output registers with their valid bits, rr0, rr1, and conflict_count.

## Timing
- Reset values:
  - out0_valid = out1_valid = 0
  - out0_packet = out1_packet = 0
  - rr0 = rr1 = 0 (input 0 favoured)
  - conflict_count = 0
  - in0_ready / in1_ready = 0 while reset is high
- Reset asserted mid-operation drops held packets. It takes priority over any load in that cycle.
- Latency: a packet accepted in cycle N appears with outj_valid = 1 in cycle N+1.
- Throughput: one packet per output per cycle, sustained under continuous out_ready.
- Backpressure: when outj_ready = 0 and outj_valid = 1, every request to output j is stalled (ready = 0). rr_j and the counter do not change.
- A stall on one output does not block an input targeting the other output.

## Test plan
- Reset: hold reset 2 cycles with both in_valid = 1 -> in_ready = 0, out_valid = 0, packets = 0, conflict_count = 0.
- Single route: in0 data = 0x1234, a = 3, b = 5, lvl = 1; a^b = 6, so bit1 = 1 -> in0_ready = 1 in cycle 0; cycle 1 has out1_valid = 1 and out1_packet = {0x1234, 3, 5, 2}; out0_valid = 0.
- Contention: both inputs continuously valid with lvl = 0, a = 2, b = 0 (bit0 = 0), out0_ready = 1 -> grants in0, in1, in0, in1 over 4 cycles; conflict_count = 4.
- Parallel: in0 targets out0 and in1 targets out1 in the same cycle -> both ready = 1; both outputs valid next cycle; conflict_count unchanged.
- Backpressure: out0 full with out0_ready = 0 for 3 cycles and in0 requesting out0 -> in0_ready = 0, out0_packet unchanged. In the cycle out0_ready = 1, in0 is accepted and out0_valid stays 1 with the new packet.
- Level wrap and reset mid-flight: lvl = 7 -> routed to out0, output lvl = 0. Then assert reset while out1_valid = 1 -> next cycle out1_valid = 0, rr0 = rr1 = 0, conflict_count = 0.
